// File: rtl/panel_pkg.sv
// Shared types and parameter defaults for the front-panel switch sequencer.
package panel_pkg;

  localparam int unsigned DEBOUNCE_CYCLES_DEF = 250000;
  localparam int unsigned TIMEOUT_CYCLES_DEF  = 1024;
  localparam int unsigned REPEAT_CYCLES_DEF   = 12500000;

  typedef enum logic [2:0] {
    CMD_NONE,
    CMD_EXAMINE,
    CMD_EXAMINE_NEXT,
    CMD_DEPOSIT,
    CMD_DEPOSIT_NEXT
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RD,
    HOLD
  } state_t;

  // Press vector bit order: 0 examine, 1 examine_next, 2 deposit, 3 deposit_next.
  function automatic cmd_t cmd_from_press(input logic [3:0] p);
    cmd_t c;
    if (p[0])      c = CMD_EXAMINE;
    else if (p[1]) c = CMD_EXAMINE_NEXT;
    else if (p[2]) c = CMD_DEPOSIT;
    else if (p[3]) c = CMD_DEPOSIT_NEXT;
    else           c = CMD_NONE;
    return c;
  endfunction

endpackage

// File: rtl/panel_switch_seq_if.sv
// Front-panel switch / command-pulse bundle; state is exported for observation.
interface panel_switch_seq_if import panel_pkg::*; ;
  logic   sw_examine;
  logic   sw_examine_next;
  logic   sw_deposit;
  logic   sw_deposit_next;
  logic   rd;
  logic   examine;
  logic   examine_next;
  logic   deposit;
  logic   deposit_next;
  logic   busy;
  logic   timeout;
  state_t state;

  // Handshake: a command pulse is acknowledged by a rd rising edge while the
  // sequencer waits for it; no edge within the timeout window sets timeout.
  modport master (
    output sw_examine, sw_examine_next, sw_deposit, sw_deposit_next, rd,
    input  examine, examine_next, deposit, deposit_next, busy, timeout, state
  );

  modport slave (
    input  sw_examine, sw_examine_next, sw_deposit, sw_deposit_next, rd,
    output examine, examine_next, deposit, deposit_next, busy, timeout, state
  );
endinterface

// File: rtl/switch_debounce.sv
// Two-flop synchroniser followed by a consecutive-cycle debouncer for one switch.
module switch_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic sw,
  output logic level
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      s1 <= sw;
      s2 <= s1;
      // Any cycle where the input agrees with the accepted level restarts the run.
      if (s2 != level) begin
        if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
          level <= s2;
          cnt   <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end
endmodule

// File: rtl/panel_switch_seq.sv
// Front-panel examine/deposit sequencer: debounced presses become single command
// pulses acknowledged by a CPU rd edge. Optional auto-repeat: PANEL_AUTOREPEAT_EN.
module panel_switch_seq import panel_pkg::*; #(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned TIMEOUT_CYCLES  = TIMEOUT_CYCLES_DEF,
  parameter int unsigned REPEAT_CYCLES   = REPEAT_CYCLES_DEF
) (
  input logic               clk,
  input logic               reset,
  panel_switch_seq_if.slave bus
);
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);

  logic [3:0]     sw_raw;
  logic [3:0]     lvl;
  logic [3:0]     lvl_q;
  logic [3:0]     press_q;
  logic           rd_q;
  logic           rd_edge;
  state_t         state;
  state_t         next_state;
  cmd_t           cmd_q;
  cmd_t           next_cmd;
  logic [TCW-1:0] tcnt;
  logic           set_timeout;
  logic           timeout_q;
  logic           examine_q;
  logic           examine_next_q;
  logic           deposit_q;
  logic           deposit_next_q;

  assign sw_raw = {bus.sw_deposit_next, bus.sw_deposit, bus.sw_examine_next, bus.sw_examine};

  for (genvar i = 0; i < 4; i++) begin : g_sw
    switch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk   (clk),
      .reset (reset),
      .sw    (sw_raw[i]),
      .level (lvl[i])
    );
  end

  assign rd_edge = bus.rd & ~rd_q;

`ifdef PANEL_AUTOREPEAT_EN
  localparam int RCW = $clog2(REPEAT_CYCLES + 1);
  logic [RCW-1:0] rcnt;
  logic           rep_level;

  // Only the "next" commands repeat; the count runs from the issued pulse onward.
  assign rep_level = (cmd_q == CMD_EXAMINE_NEXT) ? lvl[1] :
                     (cmd_q == CMD_DEPOSIT_NEXT) ? lvl[3] : 1'b0;

  always_ff @(posedge clk) begin
    if (reset) begin
      rcnt <= '0;
    end else if (next_state == ISSUE || !rep_level) begin
      rcnt <= '0;
    end else if (state != IDLE && rcnt < RCW'(REPEAT_CYCLES)) begin
      rcnt <= rcnt + RCW'(1);
    end
  end
`else
  // Keeps the repeat interval parameter referenced in builds without auto-repeat.
  localparam int unsigned unused_repeat_cycles = REPEAT_CYCLES;
`endif

  always_comb begin
    next_state  = state;
    set_timeout = 1'b0;
    next_cmd    = (state == IDLE) ? cmd_from_press(press_q) : cmd_q;
    case (state)
      IDLE:    if (|press_q) next_state = ISSUE;
      ISSUE:   next_state = WAIT_RD;
      WAIT_RD: begin
        if (rd_edge) begin
          next_state = HOLD;
        end else if (tcnt == TCW'(TIMEOUT_CYCLES - 1)) begin
          set_timeout = 1'b1;
          next_state  = HOLD;
        end
      end
      HOLD: begin
        if (lvl == 4'b0000) next_state = IDLE;
`ifdef PANEL_AUTOREPEAT_EN
        else if (rep_level && rcnt >= RCW'(REPEAT_CYCLES)) next_state = ISSUE;
`endif
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      cmd_q          <= CMD_NONE;
      lvl_q          <= '0;
      press_q        <= '0;
      rd_q           <= 1'b0;
      tcnt           <= '0;
      timeout_q      <= 1'b0;
      examine_q      <= 1'b0;
      examine_next_q <= 1'b0;
      deposit_q      <= 1'b0;
      deposit_next_q <= 1'b0;
    end else begin
      state   <= next_state;
      lvl_q   <= lvl;
      press_q <= lvl & ~lvl_q;
      rd_q    <= bus.rd;
      tcnt    <= (state == WAIT_RD) ? tcnt + TCW'(1) : '0;
      if (next_state == ISSUE) cmd_q <= next_cmd;
      // Pulses are registered so they coincide exactly with the ISSUE cycle.
      examine_q      <= (next_state == ISSUE) && (next_cmd == CMD_EXAMINE);
      examine_next_q <= (next_state == ISSUE) && (next_cmd == CMD_EXAMINE_NEXT);
      deposit_q      <= (next_state == ISSUE) && (next_cmd == CMD_DEPOSIT);
      deposit_next_q <= (next_state == ISSUE) && (next_cmd == CMD_DEPOSIT_NEXT);
      if (next_state == ISSUE)  timeout_q <= 1'b0;
      else if (set_timeout)     timeout_q <= 1'b1;
    end
  end

  assign bus.examine      = examine_q;
  assign bus.examine_next = examine_next_q;
  assign bus.deposit      = deposit_q;
  assign bus.deposit_next = deposit_next_q;
  assign bus.busy         = (state != IDLE);
  assign bus.timeout      = timeout_q;
  assign bus.state        = state;
endmodule
